// File: rtl/swivm_mmu.sv
// rtl/swivm_mmu.sv - SwiVM memory management unit: RAM owner, byte/half/word access, single-level paging
// Optional feature: define MMU_TLB_EN to add a one-entry TLB that skips the PTE fetch on a VPN hit.
module swivm_mmu #(
  parameter int    MEM_BYTES = 65536,
  parameter string INIT_FILE = ""
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] addr,
  input  logic [31:0] wrdata,
  input  logic [1:0]  size,
  input  logic [3:0]  mmu_cmd,
  input  logic        mmu_validcmd,
  input  logic        usermode,
  output logic [31:0] rddata,
  output logic        rddata_valid,
  output logic [3:0]  mmu_error
);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 4;

  localparam logic [3:0] CMD_READ    = 4'd0;
  localparam logic [3:0] CMD_WRITE   = 4'd1;
  localparam logic [3:0] CMD_SETPTBR = 4'd2;
  localparam logic [3:0] CMD_PGON    = 4'd3;
  localparam logic [3:0] CMD_PGOFF   = 4'd4;

  localparam logic [3:0] ERR_OK         = 4'd0;
  localparam logic [3:0] ERR_BADCMD     = 4'd1;
  localparam logic [3:0] ERR_PRIV       = 4'd2;
  localparam logic [3:0] ERR_ALIGN      = 4'd3;
  localparam logic [3:0] ERR_NOTPRESENT = 4'd4;
  localparam logic [3:0] ERR_USERPROT   = 4'd5;
  localparam logic [3:0] ERR_WRPROT     = 4'd6;

  typedef enum logic [1:0] {S_IDLE, S_PTE, S_ACCESS} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [31:0]   va_q, va_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [1:0]    size_q, size_d;
  logic          user_q, user_d;
  logic [3:0]    err_q, err_d;
  logic [AW-1:0] pa_q, pa_d;
  logic          paging_q, paging_d;
  logic [31:0]   ptbr_q, ptbr_d;
  logic [31:0]   rddata_q, rddata_d;
  logic          valid_q, valid_d;
  logic [3:0]    mmu_error_q, mmu_error_d;
`ifdef MMU_TLB_EN
  logic          tlb_valid_q, tlb_valid_d;
  logic [19:0]   tlb_vpn_q, tlb_vpn_d;
  logic [22:0]   tlb_pte_q, tlb_pte_d;  // {PFN, U, W, P}
`endif

  logic [31:0] mem [WORDS];
  logic [31:0] pte_addr, pte_word, acc_word, acc_shift, pa_full;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        unused_bits;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'b10 && lo[0]) || (sz == 2'b11 && lo != 2'b00);
  endfunction

  // Supervisor accesses ignore the U and W bits; only Present is enforced.
  function automatic logic [3:0] pte_check(input logic [2:0] uwp, input logic user,
                                           input logic is_write);
    if (!uwp[0])                        return ERR_NOTPRESENT;
    if (user && !uwp[2])                return ERR_USERPROT;
    if (user && is_write && !uwp[1])    return ERR_WRPROT;
    return ERR_OK;
  endfunction

  assign pte_addr  = ptbr_q + {10'd0, va_q[31:12], 2'b00};
  assign pte_word  = mem[pte_addr[AW-1:2]];
  assign acc_word  = mem[pa_q[AW-1:2]];
  assign acc_shift = acc_word >> {pa_q[1:0], 3'b000};
  assign unused_bits = ^{pte_addr[31:AW], pte_addr[1:0], pte_word[11:3], pa_full[31:AW]};

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    va_d        = va_q;
    wdat_d      = wdat_q;
    size_d      = size_q;
    user_d      = user_q;
    err_d       = err_q;
    pa_d        = pa_q;
    paging_d    = paging_q;
    ptbr_d      = ptbr_q;
    rddata_d    = rddata_q;
    valid_d     = 1'b0;
    mmu_error_d = mmu_error_q;
    pa_full     = addr;
    mem_we      = 1'b0;
    mem_be      = 4'h0;
    mem_wdata   = 32'h0;
`ifdef MMU_TLB_EN
    tlb_valid_d = tlb_valid_q;
    tlb_vpn_d   = tlb_vpn_q;
    tlb_pte_d   = tlb_pte_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (mmu_validcmd) begin
          cmd_d       = mmu_cmd;
          va_d        = addr;
          wdat_d      = wrdata;
          size_d      = size;
          user_d      = usermode;
          rddata_d    = 32'h0;
          mmu_error_d = ERR_OK;
          err_d       = ERR_OK;
          state_d     = S_ACCESS;
          if (mmu_cmd > CMD_PGOFF) begin
            err_d = ERR_BADCMD;
          end else if (usermode && mmu_cmd >= CMD_SETPTBR) begin
            err_d = ERR_PRIV;
          end else if (mmu_cmd <= CMD_WRITE && misaligned(size, addr[1:0])) begin
            err_d = ERR_ALIGN;
          end else if (mmu_cmd <= CMD_WRITE && paging_q) begin
`ifdef MMU_TLB_EN
            if (tlb_valid_q && tlb_vpn_q == addr[31:12]) begin
              err_d   = pte_check(tlb_pte_q[2:0], usermode, mmu_cmd == CMD_WRITE);
              pa_full = {tlb_pte_q[22:3], addr[11:0]};
            end else begin
              state_d = S_PTE;
            end
`else
            state_d = S_PTE;
`endif
          end
          pa_d = pa_full[AW-1:0];
        end
      end

      S_PTE: begin
        err_d   = pte_check(pte_word[2:0], user_q, cmd_q == CMD_WRITE);
        pa_full = {pte_word[31:12], va_q[11:0]};
        pa_d    = pa_full[AW-1:0];
`ifdef MMU_TLB_EN
        if (err_d == ERR_OK) begin
          tlb_valid_d = 1'b1;
          tlb_vpn_d   = va_q[31:12];
          tlb_pte_d   = {pte_word[31:12], pte_word[2:0]};
        end
`endif
        state_d = S_ACCESS;
      end

      S_ACCESS: begin
        state_d     = S_IDLE;
        valid_d     = 1'b1;
        mmu_error_d = err_q;
        if (err_q == ERR_OK) begin
          unique case (cmd_q)
            CMD_READ: begin
              unique case (size_q)
                2'b11:   rddata_d = acc_shift;
                2'b10:   rddata_d = {16'h0, acc_shift[15:0]};
                default: rddata_d = {24'h0, acc_shift[7:0]};
              endcase
            end
            CMD_WRITE: begin
              mem_we = 1'b1;
              unique case (size_q)
                2'b11: begin
                  mem_be    = 4'hF;
                  mem_wdata = wdat_q;
                end
                2'b10: begin
                  mem_be    = 4'b0011 << pa_q[1:0];
                  mem_wdata = {2{wdat_q[15:0]}};
                end
                default: begin
                  mem_be    = 4'b0001 << pa_q[1:0];
                  mem_wdata = {4{wdat_q[7:0]}};
                end
              endcase
`ifdef MMU_TLB_EN
              tlb_valid_d = 1'b0;
`endif
            end
            CMD_SETPTBR: begin
              ptbr_d = wdat_q;
`ifdef MMU_TLB_EN
              tlb_valid_d = 1'b0;
`endif
            end
            CMD_PGON: begin
              paging_d = 1'b1;
`ifdef MMU_TLB_EN
              tlb_valid_d = 1'b0;
`endif
            end
            CMD_PGOFF: begin
              paging_d = 1'b0;
`ifdef MMU_TLB_EN
              tlb_valid_d = 1'b0;
`endif
            end
            default: ;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      paging_q    <= 1'b0;
      ptbr_q      <= 32'h0;
      rddata_q    <= 32'h0;
      valid_q     <= 1'b0;
      mmu_error_q <= ERR_OK;
`ifdef MMU_TLB_EN
      tlb_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      paging_q    <= paging_d;
      ptbr_q      <= ptbr_d;
      rddata_q    <= rddata_d;
      valid_q     <= valid_d;
      mmu_error_q <= mmu_error_d;
`ifdef MMU_TLB_EN
      tlb_valid_q <= tlb_valid_d;
`endif
    end
  end

  // Request capture and TLB payload need no reset: they are only consumed behind state/valid flags.
  always_ff @(posedge i_clk) begin
    cmd_q  <= cmd_d;
    va_q   <= va_d;
    wdat_q <= wdat_d;
    size_q <= size_d;
    user_q <= user_d;
    err_q  <= err_d;
    pa_q   <= pa_d;
`ifdef MMU_TLB_EN
    tlb_vpn_q <= tlb_vpn_d;
    tlb_pte_q <= tlb_pte_d;
`endif
  end

  // A reset landing on the commit edge must suppress the write.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_reset) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[pa_q[AW-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign rddata       = rddata_q;
  assign rddata_valid = valid_q;
  assign mmu_error    = mmu_error_q;
endmodule

// File: tb/tb_swivm_mmu.sv
// tb/tb_swivm_mmu.sv - scoreboard bench for swivm_mmu with a byte-array reference model
// Honours MMU_TLB_EN in the model's latency and translation-cache rules.
module tb_swivm_mmu;
  localparam int MEM = 65536;
  localparam logic [3:0] RD = 4'd0, WR = 4'd1, SP = 4'd2, PON = 4'd3, POFF = 4'd4;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] addr = '0, wrdata = '0;
  logic [1:0]  size = '0;
  logic [3:0]  mmu_cmd = '0;
  logic        mmu_validcmd = 1'b0, usermode = 1'b0;
  logic [31:0] rddata;
  logic        rddata_valid;
  logic [3:0]  mmu_error;

  always #5 clk = ~clk;

  swivm_mmu #(.MEM_BYTES(MEM), .INIT_FILE("")) dut (
    .i_clk(clk), .i_reset(i_reset), .addr(addr), .wrdata(wrdata), .size(size),
    .mmu_cmd(mmu_cmd), .mmu_validcmd(mmu_validcmd), .usermode(usermode),
    .rddata(rddata), .rddata_valid(rddata_valid), .mmu_error(mmu_error)
  );

  int checks = 0, passes = 0, pulses = 0;
  time acc_time = 0;
  logic [31:0] q_rd[$];
  logic [3:0]  q_err[$];
  int          q_lat[$];

  logic [7:0]  mm [MEM];
  logic        m_paging = 1'b0;
  logic [31:0] m_ptbr = '0;
  logic        m_tlb_v = 1'b0;
  logic [19:0] m_tlb_vpn = '0;
  logic [31:0] m_tlb_pte = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mword(input int unsigned a);
    return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
  endfunction

  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u,
                       output logic [31:0] rd, output logic [3:0] er, output int lat);
    int n;
    int unsigned pa;
    logic [31:0] pte;
    logic hit;
    n  = (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
    rd = '0; er = 4'd0; lat = 1;
    if (c > 4) er = 4'd1;
    else if (u && c >= 2) er = 4'd2;
    else if (c <= 1 && (a % n) != 0) er = 4'd3;
    else if (c <= 1) begin
      pa = a % MEM;
      if (m_paging) begin
        hit = 1'b0;
`ifdef MMU_TLB_EN
        hit = m_tlb_v && (m_tlb_vpn == a[31:12]);
`endif
        if (hit) pte = m_tlb_pte;
        else begin
          pte = mword(((m_ptbr + (a >> 12) * 4) % MEM) & ~32'd3);
          lat = 2;
        end
        if (!pte[0]) er = 4'd4;
        else if (u && !pte[2]) er = 4'd5;
        else if (u && c == 1 && !pte[1]) er = 4'd6;
        if (er == 0 && !hit) begin
          m_tlb_v = 1'b1; m_tlb_vpn = a[31:12]; m_tlb_pte = pte;
        end
        pa = ((pte & 32'hFFFF_F000) | (a & 32'hFFF)) % MEM;
      end
      if (er == 0) begin
        if (c == RD) begin
          for (int i = 0; i < n; i++) rd = rd | (32'(mm[pa+i]) << (8*i));
        end else begin
          for (int i = 0; i < n; i++) mm[pa+i] = wd[8*i +: 8];
          m_tlb_v = 1'b0;
        end
      end
    end else begin
      if (c == SP) m_ptbr = wd;
      if (c == PON) m_paging = 1'b1;
      if (c == POFF) m_paging = 1'b0;
      m_tlb_v = 1'b0;
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u);
    logic [31:0] erd;
    logic [3:0]  eer;
    int          elat;
    model(c, a, wd, sz, u, erd, eer, elat);
    q_rd.push_back(erd); q_err.push_back(eer); q_lat.push_back(elat);
    mmu_cmd = c; addr = a; wrdata = wd; size = sz; usermode = u; mmu_validcmd = 1'b1;
    @(posedge clk);
    acc_time = $time;
    #1 mmu_validcmd = 1'b0;
    for (int i = 0; i < 8 && q_rd.size() != 0; i++) @(negedge clk);
    if (q_rd.size() != 0) begin
      checks++;
      $display("FAIL timeout: cmd %0d addr %h got no rddata_valid within 8 cycles", c, a);
      q_rd.delete(); q_err.delete(); q_lat.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rddata_valid) begin
      pulses++;
      if (q_rd.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: got rddata_valid=1 expected 0 at %0t", $time);
      end else begin
        chk("rddata", rddata, q_rd.pop_front());
        chk("mmu_error", {28'h0, mmu_error}, {28'h0, q_err.pop_front()});
        chk("latency", 32'((($time - 5) - acc_time) / 10), 32'(q_lat.pop_front()));
      end
    end
  end

  initial begin
    int p0, pg, n, r;
    logic [31:0] a;
    logic [3:0]  c;
    logic [1:0]  sz;
    logic        u;
    for (int i = 0; i < MEM; i++) mm[i] = 8'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", {31'h0, rddata_valid}, 32'h0);
    chk("reset_error", {28'h0, mmu_error}, 32'h0);
    chk("reset_rddata", rddata, 32'h0);
    @(posedge clk); #1 i_reset = 1'b0;

    issue(WR, 32'h100, 32'hDEADBEEF, 2'b11, 1'b0);
    issue(RD, 32'h100, 32'h0, 2'b11, 1'b0);
    issue(WR, 32'h103, 32'h000000AA, 2'b00, 1'b0);
    issue(RD, 32'h100, 32'h0, 2'b11, 1'b0);
    issue(RD, 32'h102, 32'h0, 2'b10, 1'b0);
    issue(RD, 32'h102, 32'h0, 2'b11, 1'b0);
    issue(SP, 32'h0, 32'h1234, 2'b11, 1'b1);
    issue(4'hF, 32'h100, 32'h0, 2'b11, 1'b0);
    issue(RD, 32'h100, 32'h0, 2'b11, 1'b0);

    issue(WR, 32'h3010, 32'h12345678, 2'b11, 1'b0);
    issue(WR, 32'h2014, 32'h00003007, 2'b11, 1'b0);
    issue(SP, 32'h0, 32'h2000, 2'b11, 1'b0);
    issue(PON, 32'h0, 32'h0, 2'b11, 1'b0);
    issue(RD, 32'h5010, 32'h0, 2'b11, 1'b0);
    issue(RD, 32'h5010, 32'h0, 2'b11, 1'b0);
    issue(WR, 32'h5010, 32'hCAFEF00D, 2'b11, 1'b0);
    issue(RD, 32'h5010, 32'h0, 2'b11, 1'b0);
    foreach (q_lat[i]) ;
    issue(POFF, 0, 0, 2'b11, 1'b0); issue(WR, 32'h2014, 32'h3005, 2'b11, 1'b0); issue(PON, 0, 0, 2'b11, 1'b0);
    issue(WR, 32'h5010, 32'h0BAD0BAD, 2'b11, 1'b1);
    issue(POFF, 0, 0, 2'b11, 1'b0); issue(WR, 32'h2014, 32'h3006, 2'b11, 1'b0); issue(PON, 0, 0, 2'b11, 1'b0);
    issue(RD, 32'h5010, 32'h0, 2'b11, 1'b0);
    issue(POFF, 0, 0, 2'b11, 1'b0); issue(WR, 32'h2014, 32'h3003, 2'b11, 1'b0); issue(PON, 0, 0, 2'b11, 1'b0);
    issue(RD, 32'h5010, 32'h0, 2'b11, 1'b1);
    issue(POFF, 0, 0, 2'b11, 1'b0); issue(WR, 32'h2014, 32'h3007, 2'b11, 1'b0); issue(PON, 0, 0, 2'b11, 1'b0);

    mmu_cmd = WR; addr = 32'h5010; wrdata = 32'h11111111; size = 2'b11; usermode = 1'b0;
    mmu_validcmd = 1'b1;
    @(posedge clk);
    #1 mmu_validcmd = 1'b0; i_reset = 1'b1; p0 = pulses;
    @(posedge clk);
    #1 i_reset = 1'b0;
    m_paging = 1'b0; m_ptbr = '0; m_tlb_v = 1'b0;
    repeat (4) @(negedge clk);
    chk("midop_no_pulse", 32'(pulses), 32'(p0));
    chk("midop_error", {28'h0, mmu_error}, 32'h0);
    chk("midop_valid", {31'h0, rddata_valid}, 32'h0);
    issue(RD, 32'h3010, 32'h0, 2'b11, 1'b0);

    for (int k = 0; k < 3; k++) begin
      pg = (k == 2) ? 3 : k;
      for (int w = 0; w < 1024; w++) issue(WR, 32'(pg * 4096 + 4 * w), $urandom, 2'b11, 1'b0);
    end
    for (int v = 0; v < 8; v++) begin
      r  = $urandom_range(0, 2);
      pg = (r == 2) ? 3 : r;
      a  = {12'h0, 20'(pg), 9'h0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3))};
      issue(WR, 32'h2000 + 32'(4 * v), a, 2'b11, 1'b0);
    end
    issue(SP, 0, 32'h2000, 2'b11, 1'b0);

    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 99);
      u  = ($urandom_range(0, 3) == 0);
      sz = 2'($urandom_range(0, 3));
      n  = (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
      if (r < 3) c = 4'($urandom_range(5, 15));
      else if (r < 9) c = PON;
      else if (r < 14) c = POFF;
      else if (r < 16) c = SP;
      else c = (r % 2 == 0) ? RD : WR;
      if (m_paging) a = {17'h0, 3'($urandom_range(0, 7)), 12'($urandom)};
      else begin
        r  = $urandom_range(0, 2);
        pg = (r == 2) ? 3 : r;
        a  = {16'($urandom), 4'(pg), 12'($urandom)};
      end
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      issue(c, a, (c == SP) ? 32'h2000 : $urandom, sz, u);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
